// File: rtl/audio_sample_sequencer.sv
// Flash-backed sample sequencer: one 16-bit sample per sample_tick, two samples per 32-bit word.
// Build option AUDIO_SEQ_LOOP_EN: when defined the region wraps forever and done stays 0.
module audio_sample_sequencer #(
  parameter int unsigned       ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(23'h000000),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h07FFFF)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir_fwd,
  input  logic              restart,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_data,
  output logic              audio_valid,
  output logic              overrun,
  output logic              done
);

`ifdef AUDIO_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT_DATA,
    S_EMIT
  } state_t;

  state_t      state;
  logic [31:0] word;
  logic        need_word;
  logic        half;
  logic        restart_pend;
  logic        done_r;
  logic        apply_restart;
  logic        sel_hi;
  logic [31:0] emit_word;
  logic [15:0] emit_sample;

  // A restart seen while a read is outstanding is only applied once the read completes.
  always_comb begin
    apply_restart = 1'b0;
    case (state)
      S_IDLE, S_FETCH: apply_restart = restart;
      S_WAIT_DATA:     apply_restart = flash_readdatavalid && (restart || restart_pend);
      S_EMIT:          apply_restart = restart || restart_pend;
      default:         apply_restart = 1'b0;
    endcase
  end

  assign sel_hi      = half ^ ~dir_fwd;
  assign emit_word   = (state == S_WAIT_DATA) ? flash_readdata : word;
  assign emit_sample = sel_hi ? emit_word[31:16] : emit_word[15:0];
  assign done        = done_r;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      flash_read   <= 1'b0;
      flash_addr   <= START_ADDR;
      word         <= '0;
      need_word    <= 1'b1;
      half         <= 1'b0;
      restart_pend <= 1'b0;
      done_r       <= 1'b0;
      audio_data   <= '0;
      audio_valid  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      if (sample_tick && (state != S_IDLE))
        overrun <= 1'b1;

      if (apply_restart) begin
        state        <= S_IDLE;
        flash_read   <= 1'b0;
        flash_addr   <= dir_fwd ? START_ADDR : END_ADDR;
        need_word    <= 1'b1;
        half         <= 1'b0;
        restart_pend <= 1'b0;
        done_r       <= 1'b0;
        overrun      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sample_tick && play && !done_r)
              state <= S_FETCH;
          end
          S_FETCH: begin
            if (need_word) begin
              flash_read <= 1'b1;
              state      <= S_REQ;
            end else begin
              audio_data  <= emit_sample;
              audio_valid <= 1'b1;
              state       <= S_EMIT;
            end
          end
          S_REQ: begin
            if (restart)
              restart_pend <= 1'b1;
            if (!flash_waitrequest) begin
              flash_read <= 1'b0;
              state      <= S_WAIT_DATA;
            end
          end
          S_WAIT_DATA: begin
            if (restart)
              restart_pend <= 1'b1;
            if (flash_readdatavalid) begin
              word        <= flash_readdata;
              need_word   <= 1'b0;
              audio_data  <= emit_sample;
              audio_valid <= 1'b1;
              state       <= S_EMIT;
            end
          end
          S_EMIT: begin
            state <= S_IDLE;
            half  <= ~half;
            if (half) begin
              need_word <= 1'b1;
              if (dir_fwd) begin
                if (flash_addr == END_ADDR) begin
                  if (LOOP_EN) flash_addr <= START_ADDR;
                  else         done_r     <= 1'b1;
                end else begin
                  flash_addr <= flash_addr + ADDR_W'(1);
                end
              end else begin
                if (flash_addr == START_ADDR) begin
                  if (LOOP_EN) flash_addr <= END_ADDR;
                  else         done_r     <= 1'b1;
                end else begin
                  flash_addr <= flash_addr - ADDR_W'(1);
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer (4-word region 0..3) with a scripted Avalon slave.
module tb_audio_sample_sequencer;
  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        play = 1'b0;
  logic        dir_fwd = 1'b1;
  logic        restart = 1'b0;
  logic        flash_read;
  logic [3:0]  flash_addr;
  logic        flash_waitrequest = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic [15:0] audio_data;
  logic        audio_valid;
  logic        overrun;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  audio_sample_sequencer #(
    .ADDR_W    (4),
    .START_ADDR(4'h0),
    .END_ADDR  (4'h3)
  ) dut (
    .CLOCK_50           (CLOCK_50),
    .reset_n            (reset_n),
    .sample_tick        (sample_tick),
    .play               (play),
    .dir_fwd            (dir_fwd),
    .restart            (restart),
    .flash_read         (flash_read),
    .flash_addr         (flash_addr),
    .flash_waitrequest  (flash_waitrequest),
    .flash_readdata     (flash_readdata),
    .flash_readdatavalid(flash_readdatavalid),
    .audio_data         (audio_data),
    .audio_valid        (audio_valid),
    .overrun            (overrun),
    .done               (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        fwd;
    logic        rst;
    int          stall;
    logic        fetch;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        valid;
    logic [15:0] sample;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse_restart(input logic fwd);
    dir_fwd = fwd;
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // One tick, then 12 cycles of slave emulation; stall = cycles waitrequest is held high.
  task automatic run_tick(input string tag, input vec_t v, input logic drop_play);
    int          rd_cyc;
    int          vcnt;
    int          vcyc;
    logic [3:0]  seen_addr;
    logic [15:0] got;
    logic        pend;
    rd_cyc = 0; vcnt = 0; vcyc = -1; seen_addr = '0; got = '0; pend = 1'b0;
    if (v.rst) pulse_restart(v.fwd);
    dir_fwd = v.fwd;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    if (drop_play) play = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (audio_valid) begin
        vcnt++;
        got = audio_data;
        if (vcyc < 0) vcyc = c;
      end
      flash_readdatavalid = pend;
      flash_readdata      = pend ? v.data : '0;
      pend                = 1'b0;
      if (flash_read) begin
        seen_addr         = flash_addr;
        flash_waitrequest = (rd_cyc < v.stall);
        pend              = !flash_waitrequest;
        rd_cyc++;
      end else begin
        flash_waitrequest = 1'b0;
      end
      step();
    end
    flash_readdatavalid = 1'b0;
    flash_waitrequest   = 1'b0;
    chk({tag, "_read_cycles"}, 32'(rd_cyc), v.fetch ? 32'(v.stall + 1) : 32'd0);
    if (v.fetch) chk({tag, "_addr"}, 32'(seen_addr), 32'(v.addr));
    chk({tag, "_valid_count"}, 32'(vcnt), 32'(v.valid));
    if (v.valid) begin
      chk({tag, "_sample"}, 32'(got), 32'(v.sample));
      chk({tag, "_latency"}, 32'(vcyc), v.fetch ? 32'(3 + v.stall) : 32'd1);
    end
    chk({tag, "_done"}, 32'(done), 32'(v.done));
  endtask

  initial begin
    int          cnt;
    int          rds;
    logic [15:0] smp;

    // fwd basic: stall 2, cached upper half, next word
    vecs.push_back('{1'b1, 1'b0, 2, 1'b1, 4'd0, 32'hAAAA5555, 1'b1, 16'h5555, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd0, 32'h0,        1'b1, 16'hAAAA, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b1, 4'd1, 32'h11112222, 1'b1, 16'h2222, 1'b0});
    // backward after restart: upper half first, address steps down
    vecs.push_back('{1'b0, 1'b1, 1, 1'b1, 4'd3, 32'h12345678, 1'b1, 16'h1234, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b0, 4'd3, 32'h0,        1'b1, 16'h5678, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b1, 4'd2, 32'h9ABCDEF0, 1'b1, 16'h9ABC, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b0, 4'd2, 32'h0,        1'b1, 16'hDEF0, 1'b0});
    // full forward pass over the region
    vecs.push_back('{1'b1, 1'b1, 0, 1'b1, 4'd0, 32'hB000A000, 1'b1, 16'hA000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd0, 32'h0,        1'b1, 16'hB000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b1, 4'd1, 32'hB001A001, 1'b1, 16'hA001, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd1, 32'h0,        1'b1, 16'hB001, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b1, 4'd2, 32'hB002A002, 1'b1, 16'hA002, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd2, 32'h0,        1'b1, 16'hB002, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3, 1'b1, 4'd3, 32'hB003A003, 1'b1, 16'hA003, 1'b0});
`ifdef AUDIO_SEQ_LOOP_EN
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd3, 32'h0,        1'b1, 16'hB003, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b1, 4'd0, 32'hC000D000, 1'b1, 16'hD000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd0, 32'h0,        1'b1, 16'hC000, 1'b0});
`else
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd3, 32'h0,        1'b1, 16'hB003, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd0, 32'h0,        1'b0, 16'h0,    1'b1});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 4'd0, 32'h0,        1'b0, 16'h0,    1'b1});
`endif

    step();
    step();
    chk("rst_flash_read", 32'(flash_read), 32'd0);
    chk("rst_flash_addr", 32'(flash_addr), 32'd0);
    chk("rst_audio_data", 32'(audio_data), 32'd0);
    chk("rst_audio_valid", 32'(audio_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    play    = 1'b1;
    step();

    foreach (vecs[i]) run_tick($sformatf("v%0d", i), vecs[i], 1'b0);

    // overrun: a tick while waiting for data is dropped and sticks
    pulse_restart(1'b1);
    chk("ovr_done_cleared", 32'(done), 32'd0);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    step();
    chk("ovr_read_issued", 32'(flash_read), 32'd1);
    step();
    chk("ovr_pre", 32'(overrun), 32'd0);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    flash_readdata = 32'h77776666; flash_readdatavalid = 1'b1; step(); flash_readdatavalid = 1'b0;
    cnt = 0; smp = '0;
    for (int c = 0; c < 8; c++) begin
      if (audio_valid) begin cnt++; smp = audio_data; end
      step();
    end
    chk("ovr_valid_count", 32'(cnt), 32'd1);
    chk("ovr_sample", 32'(smp), 32'h6666);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    pulse_restart(1'b1);
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // restart while waiting for data: returned word is discarded
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    step();
    step();
    restart = 1'b1; step(); restart = 1'b0;
    flash_readdata = 32'h11112222; flash_readdatavalid = 1'b1; step(); flash_readdatavalid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (audio_valid) cnt++;
      step();
    end
    chk("rstw_valid_count", 32'(cnt), 32'd0);
    run_tick("rstw_next", '{1'b1, 1'b0, 0, 1'b1, 4'd0, 32'h33334444, 1'b1, 16'h4444, 1'b0}, 1'b0);

    // pause during an operation lets the sample finish
    run_tick("pause_mid", '{1'b1, 1'b0, 0, 1'b0, 4'd0, 32'h0, 1'b1, 16'h3333, 1'b0}, 1'b1);

    // paused: ticks are ignored entirely
    cnt = 0; rds = 0;
    for (int t = 0; t < 5; t++) begin
      sample_tick = 1'b1; step(); sample_tick = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (audio_valid) cnt++;
        if (flash_read) rds++;
        step();
      end
    end
    chk("pause_reads", 32'(rds), 32'd0);
    chk("pause_valids", 32'(cnt), 32'd0);
    chk("pause_overrun", 32'(overrun), 32'd0);

    // restart beats a simultaneous tick in IDLE, without overrun
    play = 1'b1; dir_fwd = 1'b0;
    restart = 1'b1; sample_tick = 1'b1; step(); restart = 1'b0; sample_tick = 1'b0;
    rds = 0;
    for (int c = 0; c < 5; c++) begin
      if (flash_read) rds++;
      step();
    end
    chk("rst_tick_reads", 32'(rds), 32'd0);
    chk("rst_tick_overrun", 32'(overrun), 32'd0);

    // async reset during a stalled read, then a stray readdatavalid
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    flash_waitrequest = 1'b1;
    step();
    chk("arst_read_before", 32'(flash_read), 32'd1);
    chk("arst_addr_before", 32'(flash_addr), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_read_now", 32'(flash_read), 32'd0);
    chk("arst_addr_now", 32'(flash_addr), 32'd0);
    flash_waitrequest   = 1'b0;
    flash_readdata      = 32'hDEADBEEF;
    flash_readdatavalid = 1'b1;
    #1 reset_n = 1'b1;
    step();
    flash_readdatavalid = 1'b0;
    cnt = 0; rds = 0;
    for (int c = 0; c < 4; c++) begin
      if (audio_valid) cnt++;
      if (flash_read) rds++;
      step();
    end
    chk("arst_stray_valids", 32'(cnt), 32'd0);
    chk("arst_stray_reads", 32'(rds), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
